// File: rtl/vector_alu_exec.sv
// Lane-wise unsigned vector ALU with single-cycle ops and a
// sequential MUL that computes one lane per clock.
module vector_alu_exec #(
   parameter int VEC_W  = 64,
   parameter int LANE_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [2:0]       dir_dst,
   input  logic [VEC_W-1:0] vA,
   input  logic [VEC_W-1:0] vB,
   output logic [VEC_W-1:0] data,
   output logic [2:0]       dir_esc,
   output logic             signal_esc
);

   localparam int NLANES = VEC_W / LANE_W;
   localparam int CW = (NLANES > 1) ? $clog2(NLANES) : 1;
   localparam int SW = (LANE_W > 1) ? $clog2(LANE_W) : 1;
   localparam logic [2:0] OP_MUL = 3'b110;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t            state_q;
   state_t            state_d;
   logic [CW-1:0]     cnt;
   logic [VEC_W-1:0]  a_q;
   logic [VEC_W-1:0]  b_q;
   logic [2:0]        dst_q;
   logic [VEC_W-1:0]  acc;
   logic [VEC_W-1:0]  alu_res;
   logic [VEC_W-1:0]  mul_next;
   logic [LANE_W-1:0] lane_prod;
   logic              accept;
   logic              last;

   function automatic logic [LANE_W-1:0] lane_op(
      input logic [2:0]        f,
      input logic [LANE_W-1:0] a,
      input logic [LANE_W-1:0] b
   );
      logic [LANE_W:0]     s;
      logic [2*LANE_W-1:0] p;
      s = {1'b0, a} + {1'b0, b};
      p = {{LANE_W{1'b0}}, a} * {{LANE_W{1'b0}}, b};
      case (f)
         3'b000:  lane_op = s[LANE_W-1:0];
         3'b001:  lane_op = a - b;
         3'b010:  lane_op = a & b;
         3'b011:  lane_op = a | b;
         3'b100:  lane_op = a ^ b;
         3'b101:  lane_op = s[LANE_W] ? '1 : s[LANE_W-1:0];
         3'b110:  lane_op = p[LANE_W-1:0];
         default: lane_op = a << b[SW-1:0];
      endcase
   endfunction

   assign accept = in_valid & in_ready;
   assign last   = (cnt == CW'(NLANES - 1));

   // Single-cycle result for every lane of the live operands
   always_comb begin
      alu_res = '0;
      for (int i = 0; i < NLANES; i++)
         alu_res[i*LANE_W +: LANE_W] =
            lane_op(op, vA[i*LANE_W +: LANE_W], vB[i*LANE_W +: LANE_W]);
   end

   // Product of the lane selected by the counter merged into acc
   always_comb begin
      lane_prod = lane_op(OP_MUL,
                          a_q[LANE_W*int'(cnt) +: LANE_W],
                          b_q[LANE_W*int'(cnt) +: LANE_W]);
      mul_next = acc;
      mul_next[LANE_W*int'(cnt) +: LANE_W] = lane_prod;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept && op == OP_MUL) state_d = S_MUL;
         S_MUL:   if (last) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      in_ready = (state_q == S_IDLE);
   end

   // Operand capture, lane stepping and write-back registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         a_q        <= '0;
         b_q        <= '0;
         dst_q      <= '0;
         acc        <= '0;
         data       <= '0;
         dir_esc    <= '0;
         signal_esc <= 1'b0;
      end else begin
         signal_esc <= 1'b0;
         if (accept) begin
            if (op == OP_MUL) begin
               a_q   <= vA;
               b_q   <= vB;
               dst_q <= dir_dst;
               cnt   <= '0;
            end else begin
               data       <= alu_res;
               dir_esc    <= dir_dst;
               signal_esc <= 1'b1;
            end
         end else if (state_q == S_MUL) begin
            acc <= mul_next;
            if (last) begin
               data       <= mul_next;
               dir_esc    <= dst_q;
               signal_esc <= 1'b1;
               cnt        <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_vector_alu_exec.sv
// Randomized and directed checks of vector_alu_exec against a
// lane-arithmetic reference model.
module tb_vector_alu_exec;

   localparam int VEC_W  = 64;
   localparam int LANE_W = 8;
   localparam int NLANES = VEC_W / LANE_W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2:0]       op = '0;
   logic [2:0]       dir_dst = '0;
   logic [VEC_W-1:0] vA = '0;
   logic [VEC_W-1:0] vB = '0;
   logic [VEC_W-1:0] data;
   logic [2:0]       dir_esc;
   logic             signal_esc;

   int checks = 0;
   int failures = 0;
   logic [VEC_W-1:0] last_data = '0;
   logic [2:0]       last_dir = '0;

   vector_alu_exec #(.VEC_W(VEC_W), .LANE_W(LANE_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op         (op),
      .dir_dst    (dir_dst),
      .vA         (vA),
      .vB         (vB),
      .data       (data),
      .dir_esc    (dir_esc),
      .signal_esc (signal_esc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [VEC_W-1:0] ref_vec(
      input int f,
      input logic [VEC_W-1:0] a,
      input logic [VEC_W-1:0] b
   );
      logic [VEC_W-1:0] r;
      int x, y, v, m;
      m = 1 << LANE_W;
      r = '0;
      for (int i = 0; i < NLANES; i++) begin
         x = int'(a[i*LANE_W +: LANE_W]);
         y = int'(b[i*LANE_W +: LANE_W]);
         case (f)
            0: v = (x + y) % m;
            1: v = (x - y + m) % m;
            2: v = x & y;
            3: v = x | y;
            4: v = x ^ y;
            5: v = (x + y > m - 1) ? m - 1 : x + y;
            6: v = (x * y) % m;
            default: v = (x << (y % LANE_W)) % m;
         endcase
         r[i*LANE_W +: LANE_W] = v[LANE_W-1:0];
      end
      return r;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_chk;
      in_valid = 1'b0;
      step();
      chk("idle_sig", 64'(signal_esc), 64'd0);
      chk("hold_data", data, last_data);
      chk("hold_dir", 64'(dir_esc), 64'(last_dir));
      chk("idle_rdy", 64'(in_ready), 64'd1);
   endtask

   task automatic do_op(input logic [2:0] f,
                        input logic [VEC_W-1:0] a,
                        input logic [VEC_W-1:0] b,
                        input logic [2:0] d);
      logic [VEC_W-1:0] e;
      e = ref_vec(int'(f), a, b);
      chk("pre_rdy", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      op = f;
      vA = a;
      vB = b;
      dir_dst = d;
      step();
      if (f != 3'd6) begin
         chk("op_sig", 64'(signal_esc), 64'd1);
         chk("op_data", data, e);
         chk("op_dir", 64'(dir_esc), 64'(d));
         last_data = e;
         last_dir = d;
      end else begin
         chk("mul_acc_sig", 64'(signal_esc), 64'd0);
         chk("mul_acc_hold", data, last_data);
         for (int k = 1; k <= NLANES; k++) begin
            chk("mul_busy", 64'(in_ready), 64'd0);
            in_valid = 1'b1;
            op = 3'd0;
            vA = {$urandom, $urandom};
            vB = {$urandom, $urandom};
            dir_dst = 3'($urandom);
            step();
            if (k < NLANES) begin
               chk("mul_sig0", 64'(signal_esc), 64'd0);
               chk("mul_hold", data, last_data);
            end else begin
               chk("mul_sig", 64'(signal_esc), 64'd1);
               chk("mul_data", data, e);
               chk("mul_dir", 64'(dir_esc), 64'(d));
               chk("mul_rdy", 64'(in_ready), 64'd1);
               last_data = e;
               last_dir = d;
            end
         end
      end
   endtask

   initial begin
      #1;
      chk("rst_data", data, 64'd0);
      chk("rst_dir", 64'(dir_esc), 64'd0);
      chk("rst_sig", 64'(signal_esc), 64'd0);
      chk("rst_rdy", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0202_0202_0202_0202, 3'd5);
      chk("add_val", data, 64'h0101_0101_0101_0101);
      do_op(3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0202_0202_0202_0202, 3'd5);
      chk("adds_val", data, 64'hFFFF_FFFF_FFFF_FFFF);
      idle_chk();

      do_op(3'd1, 64'h0, 64'h0101_0101_0101_0101, 3'd2);
      chk("sub_val", data, 64'hFFFF_FFFF_FFFF_FFFF);
      do_op(3'd7, 64'h8181_8181_8181_8181, 64'h0101_0101_0101_0101, 3'd4);
      chk("shl_val", data, 64'h0202_0202_0202_0202);
      idle_chk();

      do_op(3'd6, 64'h0807_0605_0403_0201, 64'h0202_0202_0202_0202, 3'd3);
      chk("mul_val", data, 64'h100E_0C0A_0806_0402);
      do_op(3'd0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 3'd6);
      idle_chk();

      do_op(3'd6, 64'h1010_1010_1010_1010, 64'h1010_1010_1010_1010, 3'd7);
      chk("mul_wrap", data, 64'h0);
      idle_chk();

      in_valid = 1'b1;
      op = 3'd6;
      vA = 64'h0303_0303_0303_0303;
      vB = 64'h0505_0505_0505_0505;
      dir_dst = 3'd1;
      step();
      repeat (4) step();
      rst_n = 1'b0;
      #1;
      chk("abort_data", data, 64'd0);
      chk("abort_dir", 64'(dir_esc), 64'd0);
      chk("abort_sig", 64'(signal_esc), 64'd0);
      chk("abort_rdy", 64'(in_ready), 64'd1);
      last_data = '0;
      last_dir = '0;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) idle_chk();
      do_op(3'd0, 64'h1122_3344_5566_7788, 64'h0101_0101_0101_0101, 3'd2);

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 3) == 0) idle_chk();
         do_op(3'($urandom_range(0, 7)),
               {$urandom, $urandom},
               {$urandom, $urandom},
               3'($urandom));
      end
      idle_chk();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vector_alu_exec.md
VECTOR_ALU_EXEC -- requirements
Module: vector_alu_exec

Interface
REQ-001 Parameter VEC_W, default 64, SHALL set the vector width in bits, matching the vector register width.
REQ-002 Parameter LANE_W, default 8, SHALL set the lane width; VEC_W SHALL be a multiple of LANE_W; NLANES = VEC_W/LANE_W.
REQ-003 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  system clock; all state updates on posedge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operation presented this cycle.
REQ-007 in_ready  output  1  block can accept an operation.
REQ-008 op  input  3  opcode.
REQ-009 dir_dst  input  3  destination vector register index.
REQ-010 vA, vB  input  VEC_W each  source operands, fed from the register bank read ports.
REQ-011 data  output  VEC_W  result to write back.
REQ-012 dir_esc  output  3  write-back register index.
REQ-013 signal_esc  output  1  write-back enable, one-cycle pulse.

Function
REQ-014 Lane i SHALL be bits [LANE_W*i+LANE_W-1 : LANE_W*i]; all ops SHALL be lane-wise and unsigned.
REQ-015 Opcodes SHALL be: 000 ADD mod 2^LANE_W; 001 SUB mod 2^LANE_W (A-B); 010 AND; 011 OR; 100 XOR; 101 ADDS, unsigned add saturating to all-ones; 110 MUL, low LANE_W bits of A*B; 111 SHL, A shifted left by B[log2(LANE_W)-1:0], zero fill.
REQ-016 An operation SHALL be accepted at a posedge where in_valid & in_ready; otherwise inputs SHALL be ignored.
REQ-017 in_ready SHALL be combinational and high exactly when the FSM is in IDLE.
REQ-018 The FSM SHALL have states IDLE and MUL.
REQ-019 Single-cycle ops: accepted at edge N -> data = result, dir_esc = dir_dst, signal_esc = 1 registered at edge N; signal_esc SHALL fall at edge N+1 unless another op is accepted at N+1.
REQ-020 Single-cycle ops SHALL sustain one acceptance per cycle with no bubble.
REQ-021 MUL accept at edge N SHALL capture vA, vB and dir_dst, clear lane counter, and enter MUL; signal_esc SHALL be 0 at edge N.
REQ-022 In MUL, each posedge SHALL compute exactly one lane (lane index = counter, 0 first) into an internal result register and increment the counter.
REQ-023 At the edge computing lane NLANES-1 (edge N+NLANES), data = full product vector, dir_esc = captured dir_dst, signal_esc = 1 for one cycle; FSM SHALL return to IDLE.
REQ-024 in_ready SHALL be low from edge N to edge N+NLANES; earliest next acceptance is edge N+NLANES+1.
REQ-025 In MUL, changes on vA, vB, dir_dst, op and in_valid SHALL have no effect.
REQ-026 data and dir_esc SHALL hold their last value while signal_esc = 0.
REQ-027 Lane counter width SHALL be ceil(log2(NLANES)) and SHALL not wrap beyond NLANES-1.

Reset
REQ-028 rst_n low SHALL immediately force data = 0, dir_esc = 0, signal_esc = 0, FSM = IDLE, and lane counter = 0, so in_ready = 1.
REQ-029 Reset asserted during MUL SHALL abort the operation with no write-back pulse, including after release.
REQ-030 The first acceptance SHALL be possible at the first posedge after rst_n deasserts.

Verification
REQ-031 Reset: rst_n = 0 mid-run -> data = 0, dir_esc = 0, signal_esc = 0, in_ready = 1 without waiting for a clock.
REQ-032 ADD/ADDS: vA = 0xFFFF_FFFF_FFFF_FFFF, vB = 0x0202_0202_0202_0202, dir_dst = 5. ADD -> data = 0x0101_0101_0101_0101 and dir_esc = 5 with a one-cycle signal_esc. ADDS the next cycle -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-033 SUB/SHL back-to-back: SUB with vA = 0, vB = 0x0101_0101_0101_0101 -> 0xFFFF_FFFF_FFFF_FFFF. Then SHL with vA = 0x8181_8181_8181_8181, vB = 0x0101_0101_0101_0101 -> 0x0202_0202_0202_0202. signal_esc stays high for 2 consecutive cycles.
REQ-034 MUL: vA = 0x0807_0605_0403_0201, vB = 0x0202_0202_0202_0202, dir_dst = 3 -> in_ready low for 8 cycles; single signal_esc at edge N+8 with data = 0x100E_0C0A_0806_0402 and dir_esc = 3. in_valid held high with ADD during MUL is not accepted until edge N+9.
REQ-035 MUL abort: rst_n pulsed low after edge N+4 -> no signal_esc pulse ever; in_ready = 1; next ADD produces a correct result.
REQ-036 MUL wrap: vA = vB = 0x1010_1010_1010_1010 -> data = 0x0000_0000_0000_0000 (0x100 truncated per lane).
